// File: rtl/gate_response_checker.sv
// gate_response_checker: settles gate inputs, checks output against expected function, accumulates results
module gate_response_checker #(
   parameter int OP_SEL = 0,
   parameter int SETTLE = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       cov,
   output logic             err_flag,
   output logic [1:0]       last_err_vec,
   output logic             done
);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SETL = 2'd1;
   localparam logic [1:0] CHK  = 2'd2;
   localparam logic [1:0] HLD  = 2'd3;

   if (OP_SEL < 0 || OP_SEL > 3) begin : g_bad_op
      $error("gate_response_checker: OP_SEL must be 0..3");
   end

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    stab_q, stab_d, stab_inc;
   logic [1:0]       ab_q, ab_d, ab;
   logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
   logic [3:0]       cov_q, cov_d;
   logic             flag_q, flag_d, done_q, done_d, same, exp_c;
   logic [1:0]       last_q, last_d;

   // next-state: settle counting, single-cycle check, hold until the inputs move
   always_comb begin
      ab       = {A, B};
      same     = ab == ab_q;
      exp_c    = OP_SEL == 0 ? (A & B) : OP_SEL == 1 ? (A | B) : OP_SEL == 2 ? (A ^ B) : ~(A & B);
      stab_inc = stab_q + SW'(1);
      ab_d     = ab;
      state_d  = state_q;
      stab_d   = stab_q;
      vec_d    = vec_q;
      err_d    = err_q;
      cov_d    = cov_q;
      flag_d   = flag_q;
      last_d   = last_q;
      done_d   = cov_q == 4'hF;
      case (state_q)
         IDLE: begin
            state_d = en ? SETL : IDLE;
            stab_d  = '0;
         end
         SETL: begin
            stab_d  = same ? stab_inc : '0;
            state_d = (same && stab_inc == SW'(SETTLE)) ? CHK : SETL;
         end
         CHK: begin
            state_d = same ? HLD : SETL;
            stab_d  = '0;
            if (same) begin
               vec_d     = &vec_q ? vec_q : vec_q + CNT_W'(1);
               cov_d[ab] = 1'b1;
               if (C != exp_c) begin
                  err_d  = &err_q ? err_q : err_q + CNT_W'(1);
                  flag_d = 1'b1;
                  last_d = ab;
               end
            end
         end
         default: begin
            state_d = same ? HLD : SETL;
            stab_d  = '0;
         end
      endcase
      if (!en) begin
         state_d = IDLE;
         stab_d  = '0;
         vec_d   = vec_q;
         err_d   = err_q;
         cov_d   = cov_q;
         flag_d  = flag_q;
         last_d  = last_q;
      end
   end

   // state and result registers; reset clears everything and wins over en
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         stab_q  <= '0;
         ab_q    <= '0;
         vec_q   <= '0;
         err_q   <= '0;
         cov_q   <= '0;
         flag_q  <= 1'b0;
         last_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         ab_q    <= ab_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         flag_q  <= flag_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign vec_count    = vec_q;
   assign err_count    = err_q;
   assign cov          = cov_q;
   assign err_flag     = flag_q;
   assign last_err_vec = last_q;
   assign done         = done_q;
endmodule
